mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin front end to a single block-memory port.
// One transaction in flight at a time; an ISSUE phase that sees no ready for TIMEOUT cycles is aborted with an error.
module mem_arbiter #(
  parameter int WORD_SIZE        = 32,
  parameter int BLOCK_DATA_WIDTH = 512,
  parameter int TIMEOUT          = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    rq_enable,
  input  logic [1:0]                    rq_rw,
  input  logic [2*WORD_SIZE-1:0]        rq_addr,
  input  logic [2*BLOCK_DATA_WIDTH-1:0] rq_dataout,
  output logic [1:0]                    rq_ready,
  output logic [1:0]                    rq_error,
  output logic [BLOCK_DATA_WIDTH-1:0]   resp_data,
  output logic                          mem_req_enable,
  output logic                          mem_req_rw,
  output logic [WORD_SIZE-1:0]          mem_req_addr,
  output logic [BLOCK_DATA_WIDTH-1:0]   mem_req_dataout,
  input  logic [BLOCK_DATA_WIDTH-1:0]   mem_req_datain,
  input  logic                          mem_req_ready,
  output logic                          busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next;

  logic [1:0]                  r_pend;
  logic [1:0]                  r_rw;
  logic [WORD_SIZE-1:0]        r_addr [2];
  logic [BLOCK_DATA_WIDTH-1:0] r_data [2];
  logic                        r_grant;
  logic                        r_last_grant;
  logic                        r_err;
  logic [7:0]                  r_cnt;
  logic [BLOCK_DATA_WIDTH-1:0] r_resp;

  logic [1:0]                  w_clear;
  logic [1:0]                  w_capture;
  logic                        w_pick;
  logic                        w_timeout;

  // A slot being released in RESP may be refilled in that same cycle.
  always_comb begin
    w_clear   = (r_state == ST_RESP) ? (2'b01 << r_grant) : 2'b00;
    w_capture = rq_enable & (~r_pend | w_clear);
    w_pick    = (r_pend == 2'b11) ? ~r_last_grant : r_pend[1];
    w_timeout = (r_cnt == 8'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    mem_req_enable  = 1'b0;
    mem_req_rw      = 1'b0;
    mem_req_addr    = '0;
    mem_req_dataout = '0;
    rq_ready        = 2'b00;
    rq_error        = 2'b00;
    busy            = (r_state != ST_IDLE);
    resp_data       = r_resp;
    case (r_state)
      ST_IDLE: begin
        if (|r_pend) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_req_enable  = 1'b1;
        mem_req_rw      = r_rw[r_grant];
        mem_req_addr    = r_addr[r_grant];
        mem_req_dataout = r_data[r_grant];
        if (mem_req_ready || w_timeout) w_next = ST_RESP;
      end
      ST_RESP: begin
        rq_ready = 2'b01 << r_grant;
        rq_error = r_err ? (2'b01 << r_grant) : 2'b00;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= '0;
      r_rw         <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_resp       <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (w_capture[i]) begin
          r_addr[i] <= rq_addr[i*WORD_SIZE +: WORD_SIZE];
          r_data[i] <= rq_dataout[i*BLOCK_DATA_WIDTH +: BLOCK_DATA_WIDTH];
          r_rw[i]   <= rq_rw[i];
        end
      end
      r_pend <= w_capture | (r_pend & ~w_clear);

      case (r_state)
        ST_IDLE: begin
          if (|r_pend) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_cnt        <= '0;
            r_err        <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            if (!r_rw[r_grant]) r_resp <= mem_req_datain;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int WS = 32;
  localparam int BW = 512;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      rq_enable;
  logic [1:0]      rq_rw;
  logic [2*WS-1:0] rq_addr;
  logic [2*BW-1:0] rq_dataout;
  logic [1:0]      rq_ready;
  logic [1:0]      rq_error;
  logic [BW-1:0]   resp_data;
  logic            mem_req_enable;
  logic            mem_req_rw;
  logic [WS-1:0]   mem_req_addr;
  logic [BW-1:0]   mem_req_dataout;
  logic [BW-1:0]   mem_req_datain;
  logic            mem_req_ready;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] exp_resp;

  mem_arbiter #(
    .WORD_SIZE(WS),
    .BLOCK_DATA_WIDTH(BW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rq_enable(rq_enable),
    .rq_rw(rq_rw),
    .rq_addr(rq_addr),
    .rq_dataout(rq_dataout),
    .rq_ready(rq_ready),
    .rq_error(rq_error),
    .resp_data(resp_data),
    .mem_req_enable(mem_req_enable),
    .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr),
    .mem_req_dataout(mem_req_dataout),
    .mem_req_datain(mem_req_datain),
    .mem_req_ready(mem_req_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int k = 0; k < BW/32; k++) b[k*32 +: 32] = $urandom();
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    rq_enable      = '0;
    rq_rw          = '0;
    rq_addr        = '0;
    rq_dataout     = '0;
    mem_req_datain = '0;
    mem_req_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (rq_ready !== 2'b00) begin n_fail++; $display("FAIL reset_rq_ready: got %b expected 00", rq_ready); end
    n_tests++; if (rq_error !== 2'b00) begin n_fail++; $display("FAIL reset_rq_error: got %b expected 00", rq_error); end
    n_tests++; if ({busy, mem_req_enable, mem_req_rw} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {busy, mem_req_enable, mem_req_rw}); end
    n_tests++; if (mem_req_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_req_addr); end
    n_tests++; if (mem_req_dataout !== '0) begin n_fail++; $display("FAIL reset_dataout: got %h expected 0", mem_req_dataout); end
    n_tests++; if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
  endtask

  task automatic test_read();
    logic [BW-1:0] pat;
    pat = {16{32'hDEADBEEF}};
    rq_enable = 2'b01; rq_rw = 2'b00; rq_addr[WS-1:0] = 32'h0000_0ABC;
    step();
    rq_enable = 2'b00;
    n_tests++; if (mem_req_enable !== 1'b0) begin n_fail++; $display("FAIL read_early_issue: got %b expected 0", mem_req_enable); end
    step();
    n_tests++; if ({mem_req_enable, mem_req_rw} !== 2'b10) begin n_fail++; $display("FAIL read_issue_ctrl: got %b expected 10", {mem_req_enable, mem_req_rw}); end
    n_tests++; if (mem_req_addr !== 32'h0000_0ABC) begin n_fail++; $display("FAIL read_addr: got %h expected 00000abc", mem_req_addr); end
    mem_req_ready = 1'b1; mem_req_datain = pat;
    step();
    mem_req_ready = 1'b0; mem_req_datain = rand_block();
    n_tests++; if (rq_ready !== 2'b01) begin n_fail++; $display("FAIL read_rq_ready: got %b expected 01", rq_ready); end
    n_tests++; if (rq_error !== 2'b00) begin n_fail++; $display("FAIL read_rq_error: got %b expected 00", rq_error); end
    n_tests++; if (resp_data !== pat) begin n_fail++; $display("FAIL read_resp_data: got %h expected %h", resp_data, pat); end
    n_tests++; if (mem_req_enable !== 1'b0) begin n_fail++; $display("FAIL read_resp_enable: got %b expected 0", mem_req_enable); end
    step();
    n_tests++; if ({rq_ready, busy} !== 3'b000) begin n_fail++; $display("FAIL read_pulse_end: got %b expected 000", {rq_ready, busy}); end
    exp_resp = pat;
  endtask

  task automatic test_simultaneous();
    logic [BW-1:0] cafe;
    logic [BW-1:0] rd;
    cafe = {16{32'hCAFEBABE}};
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      rq_enable = 2'b11; rq_rw = 2'b10;
      rq_addr = {32'h0000_0DEF, 32'h0000_0100 + 32'(pass)};
      rq_dataout = {cafe, rand_block()};
      step();
      rq_enable = 2'b00;
      step();
      n_tests++; if ({mem_req_enable, mem_req_rw, mem_req_addr} !== {2'b10, 32'h0000_0100 + 32'(pass)}) begin
        n_fail++; $display("FAIL pair%0d_first_issue: got %h expected %h", pass, {mem_req_enable, mem_req_rw, mem_req_addr}, {2'b10, 32'h0000_0100 + 32'(pass)});
      end
      rd = rand_block();
      mem_req_ready = 1'b1; mem_req_datain = rd;
      step();
      mem_req_ready = 1'b0;
      n_tests++; if (rq_ready !== 2'b01) begin n_fail++; $display("FAIL pair%0d_first_ready: got %b expected 01", pass, rq_ready); end
      n_tests++; if (resp_data !== rd) begin n_fail++; $display("FAIL pair%0d_first_data: got %h expected %h", pass, resp_data, rd); end
      exp_resp = rd;
      step();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pair%0d_gap_busy: got %b expected 0", pass, busy); end
      step();
      n_tests++; if ({mem_req_enable, mem_req_rw, mem_req_addr} !== {2'b11, 32'h0000_0DEF}) begin
        n_fail++; $display("FAIL pair%0d_second_issue: got %h expected %h", pass, {mem_req_enable, mem_req_rw, mem_req_addr}, {2'b11, 32'h0000_0DEF});
      end
      n_tests++; if (mem_req_dataout !== cafe) begin n_fail++; $display("FAIL pair%0d_write_data: got %h expected %h", pass, mem_req_dataout, cafe); end
      mem_req_ready = 1'b1; mem_req_datain = rand_block();
      step();
      mem_req_ready = 1'b0;
      n_tests++; if ({rq_ready, rq_error} !== 4'b1000) begin n_fail++; $display("FAIL pair%0d_second_ready: got %b expected 1000", pass, {rq_ready, rq_error}); end
      n_tests++; if (resp_data !== exp_resp) begin n_fail++; $display("FAIL pair%0d_write_keeps_data: got %h expected %h", pass, resp_data, exp_resp); end
      step();
    end
  endtask

  task automatic test_timeout();
    int  n_en;
    bit  got;
    n_en = 0; got = 1'b0;
    rq_enable = 2'b10; rq_rw = 2'b00; rq_addr[2*WS-1:WS] = 32'h0000_0055;
    mem_req_ready = 1'b1; mem_req_datain = rand_block();
    step();
    rq_enable = 2'b00;
    step();
    mem_req_ready = 1'b0;
    n_tests++; if (mem_req_addr !== 32'h0000_0055) begin n_fail++; $display("FAIL timeout_addr: got %h expected 00000055", mem_req_addr); end
    for (int c = 0; c < 20 && !got; c++) begin
      if (mem_req_enable === 1'b1) n_en++;
      if (rq_ready !== 2'b00) got = 1'b1;
      else step();
    end
    n_tests++; if (!got) begin n_fail++; $display("FAIL timeout_no_response: got none expected rq_ready within 20 cycles"); end
    n_tests++; if (n_en != TO) begin n_fail++; $display("FAIL timeout_enable_cycles: got %0d expected %0d", n_en, TO); end
    n_tests++; if ({rq_ready, rq_error} !== 4'b1010) begin n_fail++; $display("FAIL timeout_flags: got %b expected 1010", {rq_ready, rq_error}); end
    n_tests++; if (resp_data !== exp_resp) begin n_fail++; $display("FAIL timeout_resp_data: got %h expected %h", resp_data, exp_resp); end
    step();
    n_tests++; if ({rq_ready, busy} !== 3'b000) begin n_fail++; $display("FAIL timeout_after: got %b expected 000", {rq_ready, busy}); end
  endtask

  task automatic test_reassert();
    logic [BW-1:0] rd;
    rq_enable = 2'b01; rq_rw = 2'b00; rq_addr[WS-1:0] = 32'h0000_00A1;
    step();
    rq_enable = 2'b00;
    step();
    n_tests++; if (mem_req_addr !== 32'h0000_00A1) begin n_fail++; $display("FAIL reassert_first_addr: got %h expected 000000a1", mem_req_addr); end
    rq_enable = 2'b01; rq_addr[WS-1:0] = 32'h0000_00A9;
    rd = rand_block(); mem_req_ready = 1'b1; mem_req_datain = rd;
    step();
    n_tests++; if (rq_ready !== 2'b01) begin n_fail++; $display("FAIL reassert_first_ready: got %b expected 01", rq_ready); end
    n_tests++; if (resp_data !== rd) begin n_fail++; $display("FAIL reassert_first_data: got %h expected %h", resp_data, rd); end
    rq_addr[WS-1:0] = 32'h0000_00A2; mem_req_ready = 1'b0;
    step();
    rq_enable = 2'b00;
    step();
    n_tests++; if ({mem_req_enable, mem_req_addr} !== {1'b1, 32'h0000_00A2}) begin
      n_fail++; $display("FAIL reassert_second_issue: got %h expected %h", {mem_req_enable, mem_req_addr}, {1'b1, 32'h0000_00A2});
    end
    rd = rand_block(); mem_req_ready = 1'b1; mem_req_datain = rd;
    step();
    mem_req_ready = 1'b0;
    n_tests++; if (rq_ready !== 2'b01) begin n_fail++; $display("FAIL reassert_second_ready: got %b expected 01", rq_ready); end
    exp_resp = rd;
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++; if ({mem_req_enable, busy} !== 2'b00) begin n_fail++; $display("FAIL reassert_dropped_c%0d: got %b expected 00", c, {mem_req_enable, busy}); end
    end
  endtask

  task automatic test_reset_mid();
    rq_enable = 2'b01; rq_rw = 2'b00; rq_addr[WS-1:0] = 32'h0000_0077;
    step();
    rq_enable = 2'b00;
    step();
    n_tests++; if (mem_req_enable !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_issue: got %b expected 1", mem_req_enable); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({mem_req_enable, busy} !== 2'b00) begin n_fail++; $display("FAIL midreset_async: got %b expected 00", {mem_req_enable, busy}); end
    n_tests++; if (mem_req_addr !== '0) begin n_fail++; $display("FAIL midreset_addr: got %h expected 0", mem_req_addr); end
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++; if ({rq_ready, busy} !== 3'b000) begin n_fail++; $display("FAIL midreset_after_c%0d: got %b expected 000", c, {rq_ready, busy}); end
    end
    mem_req_ready = 1'b0;
  endtask

  task automatic test_random();
    bit            m_pend [2];
    bit            m_rw   [2];
    logic [WS-1:0] m_addr [2];
    logic [BW-1:0] m_data [2];
    int            m_phase, m_owner, m_last, m_waited, clr;
    bit            m_err;
    logic [BW-1:0] m_resp;
    logic [1:0]    exp_ready;
    do_reset();
    for (int i = 0; i < 2; i++) begin m_pend[i] = 0; m_rw[i] = 0; m_addr[i] = '0; m_data[i] = '0; end
    m_phase = 0; m_owner = 0; m_last = 1; m_waited = 0; m_err = 0; m_resp = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      exp_ready = (m_phase == 2) ? 2'(1 << m_owner) : 2'b00;
      n_tests++; if (rq_ready !== exp_ready) begin n_fail++; $display("FAIL rand_rq_ready@%0d: got %b expected %b", cyc, rq_ready, exp_ready); end
      n_tests++; if (busy !== (m_phase != 0)) begin n_fail++; $display("FAIL rand_busy@%0d: got %b expected %b", cyc, busy, m_phase != 0); end
      n_tests++; if (mem_req_enable !== (m_phase == 1)) begin n_fail++; $display("FAIL rand_enable@%0d: got %b expected %b", cyc, mem_req_enable, m_phase == 1); end
      if (m_phase == 1) begin
        n_tests++;
        if ({mem_req_rw, mem_req_addr, mem_req_dataout} !== {m_rw[m_owner], m_addr[m_owner], m_data[m_owner]}) begin
          n_fail++; $display("FAIL rand_issue@%0d: got %h expected %h", cyc, {mem_req_rw, mem_req_addr, mem_req_dataout}, {m_rw[m_owner], m_addr[m_owner], m_data[m_owner]});
        end
      end
      if (m_phase == 2) begin
        n_tests++; if (rq_error !== (m_err ? exp_ready : 2'b00)) begin n_fail++; $display("FAIL rand_error@%0d: got %b expected %b", cyc, rq_error, m_err ? exp_ready : 2'b00); end
        n_tests++; if (resp_data !== m_resp) begin n_fail++; $display("FAIL rand_resp_data@%0d: got %h expected %h", cyc, resp_data, m_resp); end
      end

      rq_enable[0]   = ($urandom_range(0, 99) < 30);
      rq_enable[1]   = ($urandom_range(0, 99) < 30);
      rq_rw          = 2'($urandom_range(0, 3));
      rq_addr        = {$urandom(), $urandom()};
      rq_dataout     = {rand_block(), rand_block()};
      mem_req_ready  = ($urandom_range(0, 99) < 40);
      mem_req_datain = rand_block();

      clr = (m_phase == 2) ? m_owner : -1;
      case (m_phase)
        0: if (m_pend[0] || m_pend[1]) begin
             m_owner  = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[1] ? 1 : 0);
             m_last   = m_owner;
             m_waited = 0;
             m_phase  = 1;
           end
        1: begin
             m_waited++;
             if (mem_req_ready) begin
               if (!m_rw[m_owner]) m_resp = mem_req_datain;
               m_err = 0; m_phase = 2;
             end else if (m_waited == TO) begin
               m_err = 1; m_phase = 2;
             end
           end
        default: m_phase = 0;
      endcase
      for (int i = 0; i < 2; i++) begin
        if (rq_enable[i] && (!m_pend[i] || clr == i)) begin
          m_pend[i] = 1;
          m_rw[i]   = rq_rw[i];
          m_addr[i] = rq_addr[i*WS +: WS];
          m_data[i] = rq_dataout[i*BW +: BW];
        end else if (clr == i) begin
          m_pend[i] = 0;
        end
      end
    end
    @(negedge clk);
    rq_enable = 2'b00; mem_req_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_resp = '0;
    test_reset();
    test_read();
    test_simultaneous();
    test_timeout();
    test_reassert();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
